// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory stage and its UART word loader.
package mem_pkg;

  localparam int unsigned DEF_DATA_W     = 16;
  localparam int unsigned DEF_ADDR_W     = 4;
  localparam int unsigned DEF_DEPTH      = 16;
  localparam int unsigned DEF_LOAD_WORDS = 16;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } loadState_t;

  function automatic int unsigned bytesPerWord(input int unsigned dataW);
    return dataW / 8;
  endfunction

endpackage

// File: rtl/mem_stage_loader_uart_word_assembler.sv
// Packs a little-endian UART byte stream into DATA_W words; word is valid on the last byte.
module uart_word_assembler
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [7:0]        byteIn,
  input  logic              byteValid,
  output logic [DATA_W-1:0] word,
  output logic              wordValid
);

  localparam int unsigned BPW   = bytesPerWord(DATA_W);
  localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(BPW - 1);

  logic [IDX_W-1:0]  byteIdx;
  logic [DATA_W-1:0] lanes;

  // The completed word includes the byte arriving this cycle, so memory can take it on the same edge.
  always_comb begin
    word = lanes;
    word[8*int'(byteIdx) +: 8] = byteIn;
  end

  assign wordValid = byteValid && (byteIdx == LastIdx);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byteIdx <= '0;
      lanes   <= '0;
    end else if (byteValid) begin
      lanes   <= word;
      byteIdx <= wordValid ? '0 : byteIdx + 1'b1;
    end
  end

endmodule

// File: rtl/mem_stage_loader.sv
// Pipeline memory stage: data memory, pass-through to writeback, and a UART byte-stream loader.
module mem_stage_loader
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned LOAD_WORDS = DEF_LOAD_WORDS
) (
  input  logic              clk_neg,
  input  logic              reset,
  input  logic              mem_write_m,
  input  logic [ADDR_W-1:0] addr_m,
  input  logic [DATA_W-1:0] alu_result_m,
  input  logic [7:0]        uart_byte,
  input  logic              uart_byte_valid,
  input  logic              load_start,
  output logic              mem_write_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] mem_read_data_m,
  output logic              stall_m,
  output logic              load_busy,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count
);

  localparam logic [ADDR_W:0]   LoadWordsC = (ADDR_W+1)'(LOAD_WORDS);
  localparam logic [ADDR_W-1:0] LastPtr    = ADDR_W'(LOAD_WORDS - 1);

  loadState_t        state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   loadCount;
  logic              loadDone;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              loading;
  logic              addrInRange;
  logic              cpuWrite;
  logic              asmClear;
  logic              asmByteValid;
  logic [DATA_W-1:0] asmWord;
  logic              asmWordValid;

  assign loading      = (state == LD_LOAD);
  assign addrInRange  = (32'(addr_m) < DEPTH);
  assign cpuWrite     = mem_write_m && !loading && addrInRange;
  // A restart wins over a byte arriving on the same edge.
  assign asmClear     = !loading || load_start;
  assign asmByteValid = loading && uart_byte_valid && !load_start;

  uart_word_assembler #(
    .DATA_W(DATA_W)
  ) uAsm (
    .clk      (clk_neg),
    .reset    (reset),
    .clear    (asmClear),
    .byteIn   (uart_byte),
    .byteValid(asmByteValid),
    .word     (asmWord),
    .wordValid(asmWordValid)
  );

  always_ff @(posedge clk_neg) begin
    if (reset) begin
      state     <= LD_IDLE;
      ptr       <= '0;
      loadCount <= '0;
      loadDone  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[ADDR_W'(i)] <= '0;
      end
    end else begin
      if (cpuWrite) begin
        mem[addr_m] <= alu_result_m;
      end
      case (state)
        LD_IDLE, LD_DONE: begin
          if (load_start) begin
            state     <= LD_LOAD;
            ptr       <= '0;
            loadCount <= '0;
            loadDone  <= 1'b0;
          end
        end
        LD_LOAD: begin
          if (load_start) begin
            ptr       <= '0;
            loadCount <= '0;
          end else if (asmWordValid) begin
            mem[ptr] <= asmWord;
            if (loadCount != LoadWordsC) begin
              loadCount <= loadCount + 1'b1;
            end
            // ptr holds at the last slot so a session never wraps.
            if (ptr == LastPtr) begin
              state    <= LD_DONE;
              loadDone <= 1'b1;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

  assign mem_write_out   = mem_write_m;
  assign alu_result_out  = alu_result_m;
  assign mem_read_data_m = addrInRange ? mem[addr_m] : '0;
  assign stall_m         = loading;
  assign load_busy       = loading;
  assign load_done       = loadDone;
  assign load_count      = loadCount;

endmodule

// File: tb/tb_mem_stage_loader.sv
// Self-checking bench for mem_stage_loader: queue-based reference model plus directed literal checks.
module tb_mem_stage_loader;

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 4;
  localparam int unsigned DEP = 16;
  localparam int unsigned LW  = 2;
  localparam int unsigned BPW = DW / 8;

  logic          clk_neg = 1'b0;
  logic          reset;
  logic          mem_write_m;
  logic [AW-1:0] addr_m;
  logic [DW-1:0] alu_result_m;
  logic [7:0]    uart_byte;
  logic          uart_byte_valid;
  logic          load_start;
  logic          mem_write_out;
  logic [DW-1:0] alu_result_out;
  logic [DW-1:0] mem_read_data_m;
  logic          stall_m;
  logic          load_busy;
  logic          load_done;
  logic [AW:0]   load_count;

  int nVec = 0;
  int nMis = 0;

  always #5 clk_neg = ~clk_neg;

  mem_stage_loader #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .DEPTH     (DEP),
    .LOAD_WORDS(LW)
  ) dut (
    .clk_neg        (clk_neg),
    .reset          (reset),
    .mem_write_m    (mem_write_m),
    .addr_m         (addr_m),
    .alu_result_m   (alu_result_m),
    .uart_byte      (uart_byte),
    .uart_byte_valid(uart_byte_valid),
    .load_start     (load_start),
    .mem_write_out  (mem_write_out),
    .alu_result_out (alu_result_out),
    .mem_read_data_m(mem_read_data_m),
    .stall_m        (stall_m),
    .load_busy      (load_busy),
    .load_done      (load_done),
    .load_count     (load_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: session is a byte queue and a word counter.
  logic [DW-1:0] mMem [DEP];
  bit            mBusy, mDone, mValid;
  int            mCount;
  logic [7:0]    q [$];
  logic [DW-1:0] w;

  always @(posedge clk_neg) begin
    if (reset) begin
      foreach (mMem[i]) mMem[i] = '0;
      mBusy = 0; mDone = 0; mCount = 0; mValid = 1;
      q.delete();
    end else if (mValid) begin
      if (mem_write_m && !mBusy && (int'(addr_m) < DEP)) mMem[addr_m] = alu_result_m;
      if (load_start) begin
        mBusy = 1; mDone = 0; mCount = 0;
        q.delete();
      end else if (mBusy && uart_byte_valid) begin
        q.push_back(uart_byte);
        if (q.size() == BPW) begin
          w = '0;
          foreach (q[i]) w[8*i +: 8] = q[i];
          mMem[mCount] = w;
          mCount++;
          q.delete();
          if (mCount == LW) begin
            mBusy = 0; mDone = 1;
          end
        end
      end
    end
  end

  always @(negedge clk_neg) begin
    if (mValid) begin
      check("mem_write_out", mem_write_out, mem_write_m);
      check("alu_result_out", alu_result_out, alu_result_m);
      check("mem_read_data_m", mem_read_data_m, mMem[addr_m]);
      check("stall_m", stall_m, mBusy);
      check("load_busy", load_busy, mBusy);
      check("load_done", load_done, mDone);
      check("load_count", load_count, mCount);
    end
  end

  task automatic step();
    @(posedge clk_neg);
    #2;
  endtask

  task automatic sendByte(input logic [7:0] b);
    uart_byte = b;
    uart_byte_valid = 1'b1;
    step();
    uart_byte_valid = 1'b0;
  endtask

  task automatic readLit(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string nm);
    addr_m = a;
    #1;
    check(nm, mem_read_data_m, exp);
  endtask

  initial begin
    reset = 1'b1; mem_write_m = 1'b0; addr_m = '0; alu_result_m = '0;
    uart_byte = '0; uart_byte_valid = 1'b0; load_start = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_stall", stall_m, 0);
    check("rst_done", load_done, 0);
    check("rst_count", load_count, 0);

    // CPU stores and readback
    mem_write_m = 1'b1; addr_m = 4'd3; alu_result_m = 16'hBEEF; step();
    addr_m = 4'd7; alu_result_m = 16'hC0DE; step();
    mem_write_m = 1'b0;
    readLit(4'd3, 16'hBEEF, "store3");
    readLit(4'd7, 16'hC0DE, "store7");

    // Reset clears nonzero memory
    reset = 1'b1; step(); reset = 1'b0;
    for (int a = 0; a < DEP; a++) readLit(AW'(a), 16'h0000, "rst_clear");

    mem_write_m = 1'b1; addr_m = 4'd5; alu_result_m = 16'h5555; step();
    mem_write_m = 1'b0;

    // Two-word load with a suppressed CPU store in the middle
    load_start = 1'b1; step(); load_start = 1'b0;
    check("start_stall", stall_m, 1);
    sendByte(8'h34);
    mem_write_m = 1'b1; addr_m = 4'd5; alu_result_m = 16'hAAAA;
    sendByte(8'h12);
    sendByte(8'h78);
    check("mid_stall", stall_m, 1);
    sendByte(8'h56);
    mem_write_m = 1'b0;
    check("end_stall", stall_m, 0);
    check("end_done", load_done, 1);
    check("end_count", load_count, 2);
    readLit(4'd0, 16'h1234, "load_w0");
    readLit(4'd1, 16'h5678, "load_w1");
    readLit(4'd5, 16'h5555, "stalled_store");

    // Restart mid-word drops the partial word and the concurrent byte
    reset = 1'b1; step(); reset = 1'b0;
    load_start = 1'b1; step(); load_start = 1'b0;
    sendByte(8'h11);
    load_start = 1'b1; uart_byte = 8'h22; uart_byte_valid = 1'b1; step();
    load_start = 1'b0; uart_byte_valid = 1'b0;
    sendByte(8'h34);
    sendByte(8'h12);
    check("restart_count", load_count, 1);
    check("restart_busy", load_busy, 1);
    readLit(4'd0, 16'h1234, "restart_w0");

    // Reset after 3 of 4 bytes abandons the session
    load_start = 1'b1; step(); load_start = 1'b0;
    sendByte(8'hAB); sendByte(8'hCD); sendByte(8'hEF);
    reset = 1'b1; step(); reset = 1'b0;
    check("midrst_busy", load_busy, 0);
    check("midrst_done", load_done, 0);
    readLit(4'd0, 16'h0000, "midrst_w0");
    sendByte(8'h01); sendByte(8'h02); sendByte(8'h03); sendByte(8'h04);
    check("idle_ignore_count", load_count, 0);
    readLit(4'd0, 16'h0000, "idle_ignore_w0");
    readLit(4'd1, 16'h0000, "idle_ignore_w1");

    // DONE ignores bytes; a new load_start clears load_done
    load_start = 1'b1; step(); load_start = 1'b0;
    sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h44);
    check("done2", load_done, 1);
    sendByte(8'h99);
    readLit(4'd0, 16'h2211, "done_w0");
    readLit(4'd1, 16'h4433, "done_w1");
    load_start = 1'b1; step(); load_start = 1'b0;
    check("restart_done", load_done, 0);
    check("restart_cnt0", load_count, 0);
    check("restart_busy1", load_busy, 1);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
